// File: rtl/ysyx_23060136_ifu_pc_gen.sv
// ---------------------------------------------------------------------------
// ysyx_23060136_ifu_pc_gen
//
// First stage of the IFU mini pipeline. Produces the fetch PC stream that the
// IFU1->IFU2 segment register consumes. Branch-unit and predictor redirects
// are applied on the next edge when the front end is free. A redirect that
// arrives while the front end is stalled is buffered and applied on the
// first non-stalled cycle, so no redirect is ever lost.
//
// Ports:
//   clk              clock, all state updates on posedge
//   rst              synchronous active-high reset
//   BRANCH_flushIF   branch-unit redirect request
//   BRANCH_target    branch-unit redirect PC
//   BHT_flushIF      predictor redirect request
//   BHT_target       predictor redirect PC
//   FORWARD_stallIF  hold the fetch PC while high
//   IFU1_pc          current fetch PC (registered)
//   IFU1_valid       IFU1_pc is a real fetch (registered)
//   IFU1_redirect    one-cycle pulse: PC was loaded from a redirect this edge
//   IFU1_pending     a buffered redirect is waiting for stall release
// ---------------------------------------------------------------------------
module ysyx_23060136_ifu_pc_gen #(
    parameter int              BITS_W     = 32,
    parameter logic [BITS_W-1:0] PC_RST   = 32'h8000_0000,
    parameter int              INST_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              BRANCH_flushIF,
    input  logic [BITS_W-1:0] BRANCH_target,
    input  logic              BHT_flushIF,
    input  logic [BITS_W-1:0] BHT_target,
    input  logic              FORWARD_stallIF,
    output logic [BITS_W-1:0] IFU1_pc,
    output logic              IFU1_valid,
    output logic              IFU1_redirect,
    output logic              IFU1_pending
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [BITS_W-1:0] PC_INC = BITS_W'(INST_BYTES);

    // Instructions are word aligned; the low two target bits are dropped.
    function automatic logic [BITS_W-1:0] align_pc(input logic [BITS_W-1:0] t);
        align_pc = {t[BITS_W-1:2], 2'b00};
    endfunction

    state_t            state_q, state_d;
    logic [BITS_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic              redirect_q, redirect_d;
    logic              pending_q, pending_d;
    logic [BITS_W-1:0] pend_target_q, pend_target_d;
    logic              pend_is_br_q, pend_is_br_d;

    logic [BITS_W-1:0] br_tgt_s;
    logic [BITS_W-1:0] bht_tgt_s;
    logic              sel_valid_s;
    logic [BITS_W-1:0] sel_target_s;

    // Same-cycle redirect select: branch unit beats predictor.
    always_comb begin
        br_tgt_s     = align_pc(BRANCH_target);
        bht_tgt_s    = align_pc(BHT_target);
        sel_valid_s  = BRANCH_flushIF | BHT_flushIF;
        if (BRANCH_flushIF) begin
            sel_target_s = br_tgt_s;
        end else begin
            sel_target_s = bht_tgt_s;
        end
    end

    // Next-state, next-PC and pending-buffer logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        valid_d       = valid_q;
        redirect_d    = 1'b0;
        pending_d     = pending_q;
        pend_target_d = pend_target_q;
        pend_is_br_d  = pend_is_br_q;

        case (state_q)
            S_BOOT: begin
                // First fetch is PC_RST itself; inputs are ignored here.
                state_d = S_RUN;
                valid_d = 1'b1;
            end
            S_RUN: begin
                if (!FORWARD_stallIF) begin
                    if (sel_valid_s) begin
                        pc_d       = sel_target_s;
                        redirect_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_INC;
                    end
                end else begin
                    if (sel_valid_s) begin
                        pend_target_d = sel_target_s;
                        pend_is_br_d  = BRANCH_flushIF;
                        pending_d     = 1'b1;
                        state_d       = S_HOLD;
                    end else begin
                        pending_d = pending_q;
                    end
                end
            end
            S_HOLD: begin
                if (FORWARD_stallIF) begin
                    // A pending branch means the predictor is on a flushed
                    // path, so later BHT redirects must not replace it.
                    if (BRANCH_flushIF) begin
                        pend_target_d = br_tgt_s;
                        pend_is_br_d  = 1'b1;
                    end else if (BHT_flushIF && !pend_is_br_q) begin
                        pend_target_d = bht_tgt_s;
                        pend_is_br_d  = 1'b0;
                    end else begin
                        pend_target_d = pend_target_q;
                    end
                end else begin
                    if (BRANCH_flushIF) begin
                        pc_d = br_tgt_s;
                    end else if (pend_is_br_q) begin
                        pc_d = pend_target_q;
                    end else if (BHT_flushIF) begin
                        pc_d = bht_tgt_s;
                    end else begin
                        pc_d = pend_target_q;
                    end
                    redirect_d = 1'b1;
                    pending_d  = 1'b0;
                    state_d    = S_RUN;
                end
            end
            default: begin
                state_d   = S_BOOT;
                pc_d      = PC_RST;
                valid_d   = 1'b0;
                pending_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BOOT;
            pc_q          <= PC_RST;
            valid_q       <= 1'b0;
            redirect_q    <= 1'b0;
            pending_q     <= 1'b0;
            pend_target_q <= '0;
            pend_is_br_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            valid_q       <= valid_d;
            redirect_q    <= redirect_d;
            pending_q     <= pending_d;
            pend_target_q <= pend_target_d;
            pend_is_br_q  <= pend_is_br_d;
        end
    end

    assign IFU1_pc       = pc_q;
    assign IFU1_valid    = valid_q;
    assign IFU1_redirect = redirect_q;
    assign IFU1_pending  = pending_q;

endmodule
